// File: rtl/wwm_projectile_pkg.sv
// Shared types and fixed-point constants for the World War Math projectile engine.
package wwm_projectile_pkg;

    // One-hot flight states.
    typedef enum logic [2:0] {
        ST_AIM  = 3'b001,
        ST_FLY  = 3'b010,
        ST_HOLD = 3'b100
    } state_t;

    // Q-format widths: positions Q10.4 unsigned, velocities signed 1/16 px/frame.
    localparam int unsigned POS_W = 14;
    localparam int unsigned VEL_W = 12;
    localparam int unsigned FRAC  = 4;

    // Screen limits in integer pixels and in Q10.4.
    localparam logic [9:0]       SCREEN_MAX = 10'd1023;
    localparam logic [POS_W-1:0] POS_MAX    = 14'd16383;

    // Clamp a signed intermediate position into 0..POS_MAX so edges never wrap.
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [15:0] s);
        if (s < 16'sd0)
            return '0;
        else if (s > 16'sd16383)
            return POS_MAX;
        else
            return s[POS_W-1:0];
    endfunction

endpackage

// File: rtl/wwm_trig_lut.sv
// Combinational Q0.7 cosine/sine table for angles 10..80 degrees in 10-degree steps.
module wwm_trig_lut
    import wwm_projectile_pkg::*;
(
    input  logic [2:0]  idx,
    output logic [15:0] cos_sin
);

    // Table lookup: upper byte cosine, lower byte sine.
    always_comb begin
        cos_sin = '0;
        case (idx)
            3'd0: cos_sin = {8'd125, 8'd22};
            3'd1: cos_sin = {8'd119, 8'd43};
            3'd2: cos_sin = {8'd110, 8'd64};
            3'd3: cos_sin = {8'd97,  8'd82};
            3'd4: cos_sin = {8'd82,  8'd97};
            3'd5: cos_sin = {8'd64,  8'd110};
            3'd6: cos_sin = {8'd43,  8'd119};
            3'd7: cos_sin = {8'd22,  8'd125};
            default: cos_sin = '0;
        endcase
    end

endmodule

// File: rtl/wwm_projectile.sv
// Aiming and ballistic flight engine: aim counters, launch velocity, per-frame integration.
module wwm_projectile
    import wwm_projectile_pkg::*;
#(
    parameter logic [9:0] START_X = 10'd200,
    parameter logic [9:0] START_Y = 10'd460,
    parameter logic [7:0] GRAV    = 8'd4,
    parameter logic [2:0] ANG_RST = 3'd3,
    parameter logic [3:0] PWR_RST = 4'd8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frameTick,
    input  logic       q_I,
    input  logic       q_P1Shoot,
    input  logic       q_Animate,
    input  logic       q_Done,
    input  logic       angleUp,
    input  logic       angleDown,
    input  logic       powerUp,
    input  logic       powerDown,
    output logic [9:0] projectileCenterX,
    output logic [9:0] projectileCenterY,
    output logic [2:0] angleIdx,
    output logic [3:0] power,
    output logic       inFlight
);

    localparam logic [POS_W-1:0] START_PX = {START_X, 4'b0000};
    localparam logic [POS_W-1:0] START_PY = {START_Y, 4'b0000};

    state_t                   state_q, state_d;
    logic [2:0]               angle_q, angle_d;
    logic [3:0]               power_q, power_d;
    logic [POS_W-1:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0]  vx_q, vx_d, vy_q, vy_d;

    logic [15:0]              cos_sin;
    logic [11:0]              prod_cos, prod_sin;
    logic signed [VEL_W-1:0]  aim_vx, aim_vy;
    logic [POS_W-1:0]         step_x, step_y;
    logic signed [VEL_W:0]    vy_sum;
    logic signed [VEL_W-1:0]  vy_next;

    wwm_trig_lut u_trig (
        .idx     (angle_q),
        .cos_sin (cos_sin)
    );

    // Launch velocity: (power * trig) >> 3, vertical component negated because Y grows downward.
    always_comb begin
        prod_cos = {8'b0, power_q} * {4'b0, cos_sin[15:8]};
        prod_sin = {8'b0, power_q} * {4'b0, cos_sin[7:0]};
        aim_vx   = $signed({3'b000, prod_cos[11:3]});
        aim_vy   = -$signed({3'b000, prod_sin[11:3]});
    end

    // One flight step: move with the old velocity, clamp positions, then apply gravity with saturation.
    always_comb begin
        step_x = clamp_pos($signed({2'b00, pos_x_q}) + $signed({{4{vx_q[VEL_W-1]}}, vx_q}));
        step_y = clamp_pos($signed({2'b00, pos_y_q}) + $signed({{4{vy_q[VEL_W-1]}}, vy_q}));
        vy_sum = $signed({vy_q[VEL_W-1], vy_q}) + $signed({5'b00000, GRAV});
        if (vy_sum > 13'sd2047)
            vy_next = 12'sd2047;
        else
            vy_next = vy_sum[VEL_W-1:0];
    end

    // Aim counters: adjust only while the SM is in the shoot state; opposing pulses cancel.
    always_comb begin
        angle_d = angle_q;
        power_d = power_q;
        if (q_P1Shoot) begin
            if (angleUp && !angleDown && angle_q != 3'd7)
                angle_d = angle_q + 3'd1;
            else if (angleDown && !angleUp && angle_q != 3'd0)
                angle_d = angle_q - 3'd1;
            if (powerUp && !powerDown && power_q != 4'd15)
                power_d = power_q + 4'd1;
            else if (powerDown && !powerUp && power_q != 4'd1)
                power_d = power_q - 4'd1;
        end
    end

    // Flight FSM and datapath next-state; exits take priority over a coincident frame tick.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        case (state_q)
            ST_AIM: begin
                pos_x_d = START_PX;
                pos_y_d = START_PY;
                vx_d    = aim_vx;
                vy_d    = aim_vy;
                if (q_Animate)
                    state_d = ST_FLY;
            end
            ST_FLY: begin
                if (q_P1Shoot || q_I) begin
                    state_d = ST_AIM;
                    pos_x_d = START_PX;
                    pos_y_d = START_PY;
                end else if (q_Done) begin
                    state_d = ST_HOLD;
                end else if (frameTick) begin
                    pos_x_d = step_x;
                    pos_y_d = step_y;
                    vy_d    = vy_next;
                end
            end
            ST_HOLD: begin
                if (q_I || q_P1Shoot) begin
                    state_d = ST_AIM;
                    pos_x_d = START_PX;
                    pos_y_d = START_PY;
                end
            end
            default: begin
                state_d = ST_AIM;
                pos_x_d = START_PX;
                pos_y_d = START_PY;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_AIM;
            angle_q <= ANG_RST;
            power_q <= PWR_RST;
            pos_x_q <= START_PX;
            pos_y_q <= START_PY;
            vx_q    <= '0;
            vy_q    <= '0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            power_q <= power_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
        end
    end

    assign projectileCenterX = pos_x_q[POS_W-1:FRAC];
    assign projectileCenterY = pos_y_q[POS_W-1:FRAC];
    assign angleIdx          = angle_q;
    assign power             = power_q;
    assign inFlight          = (state_q == ST_FLY);

endmodule

// File: tb/tb_wwm_projectile.sv
// Directed self-checking bench for wwm_projectile.
module tb_wwm_projectile;

    logic       clk = 1'b0;
    logic       Reset;
    logic       frameTick, q_I, q_P1Shoot, q_Animate, q_Done;
    logic       angleUp, angleDown, powerUp, powerDown;
    logic [9:0] projectileCenterX, projectileCenterY;
    logic [2:0] angleIdx;
    logic [3:0] power;
    logic       inFlight;

    int errors = 0;
    int checks = 0;

    wwm_projectile dut (
        .clk               (clk),
        .Reset             (Reset),
        .frameTick         (frameTick),
        .q_I               (q_I),
        .q_P1Shoot         (q_P1Shoot),
        .q_Animate         (q_Animate),
        .q_Done            (q_Done),
        .angleUp           (angleUp),
        .angleDown         (angleDown),
        .powerUp           (powerUp),
        .powerDown         (powerDown),
        .projectileCenterX (projectileCenterX),
        .projectileCenterY (projectileCenterY),
        .angleIdx          (angleIdx),
        .power             (power),
        .inFlight          (inFlight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  mx, my, mvx, mvy;
    bit  clamped;

    initial begin
        Reset = 1'b1;
        {frameTick, q_I, q_P1Shoot, q_Animate, q_Done} = '0;
        {angleUp, angleDown, powerUp, powerDown} = '0;
        #12;
        // Reset values
        chk("rst_x", projectileCenterX, 200);
        chk("rst_y", projectileCenterY, 460);
        chk("rst_angle", angleIdx, 3);
        chk("rst_power", power, 8);
        chk("rst_inflight", inFlight, 0);
        Reset = 1'b0;
        tick();

        // Pulses ignored outside shoot state
        angleUp = 1'b1; powerDown = 1'b1; tick(); angleUp = 1'b0; powerDown = 1'b0;
        chk("ignore_angle", angleIdx, 3);
        chk("ignore_power", power, 8);

        // Aim limits
        q_P1Shoot = 1'b1;
        repeat (5) begin angleUp = 1'b1; tick(); angleUp = 1'b0; tick(); end
        chk("angle_sat_hi", angleIdx, 7);
        repeat (20) begin powerDown = 1'b1; tick(); powerDown = 1'b0; tick(); end
        chk("power_sat_lo", power, 1);
        angleUp = 1'b1; angleDown = 1'b1; powerUp = 1'b1; powerDown = 1'b1; tick();
        {angleUp, angleDown, powerUp, powerDown} = '0;
        chk("both_angle", angleIdx, 7);
        chk("both_power", power, 1);
        repeat (20) begin powerUp = 1'b1; tick(); powerUp = 1'b0; tick(); end
        chk("power_sat_hi", power, 15);
        q_P1Shoot = 1'b0;

        // Steep shot at 80 deg, power 15: vx=41, vy=-234; fly until Y clamps at the bottom edge
        q_Animate = 1'b1; tick();
        chk("fly80_inflight", inFlight, 1);
        chk("fly80_x0", projectileCenterX, 200);
        chk("fly80_y0", projectileCenterY, 460);
        mx = 3200; my = 7360; mvx = 41; mvy = -234;
        clamped = 1'b0;
        for (int i = 0; i < 400 && !clamped; i++) begin
            frameTick = 1'b1; tick(); frameTick = 1'b0;
            mx = mx + mvx;
            my = my + mvy;
            if (mx > 16383) mx = 16383;
            if (mx < 0) mx = 0;
            if (my > 16383) my = 16383;
            if (my < 0) my = 0;
            mvy = mvy + 4;
            if (mvy > 2047) mvy = 2047;
            chk("fly80_x", projectileCenterX, mx / 16);
            chk("fly80_y", projectileCenterY, my / 16);
            if (my == 16383) clamped = 1'b1;
            tick();
        end
        chk("fly80_clamp_reached", projectileCenterY, 1023);
        repeat (3) begin frameTick = 1'b1; tick(); frameTick = 1'b0; end
        chk("fly80_no_wrap", projectileCenterY, 1023);
        q_Animate = 1'b0; q_P1Shoot = 1'b1; tick();
        chk("miss_x", projectileCenterX, 200);
        chk("miss_y", projectileCenterY, 460);
        chk("miss_inflight", inFlight, 0);
        q_P1Shoot = 1'b0;

        // Default aim after reset: one tick gives posX=3297, posY=7278, then vy=-78
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        q_Animate = 1'b1; tick();
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        chk("def_x1", projectileCenterX, 206);
        chk("def_y1", projectileCenterY, 454);
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        chk("def_x2", projectileCenterX, 212);
        chk("def_y2", projectileCenterY, 450);

        // Hit: q_Done with a coincident frame tick freezes position in HOLD
        q_Animate = 1'b0; q_Done = 1'b1; frameTick = 1'b1; tick(); frameTick = 1'b0;
        chk("hold_inflight", inFlight, 0);
        chk("hold_x_entry", projectileCenterX, 212);
        chk("hold_y_entry", projectileCenterY, 450);
        repeat (10) begin frameTick = 1'b1; tick(); frameTick = 1'b0; end
        chk("hold_x", projectileCenterX, 212);
        chk("hold_y", projectileCenterY, 450);
        q_Done = 1'b0; q_I = 1'b1; tick(); q_I = 1'b0;
        chk("hold_exit_x", projectileCenterX, 200);
        chk("hold_exit_y", projectileCenterY, 460);

        // Reset mid-flight, coincident with a frame tick
        q_P1Shoot = 1'b1; powerUp = 1'b1; tick(); powerUp = 1'b0; q_P1Shoot = 1'b0;
        chk("pre_rst_power", power, 9);
        q_Animate = 1'b1; tick();
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        chk("pre_rst_x", projectileCenterX, 206);
        Reset = 1'b1; frameTick = 1'b1; #1;
        chk("async_rst_x", projectileCenterX, 200);
        chk("async_rst_y", projectileCenterY, 460);
        chk("async_rst_inflight", inFlight, 0);
        tick();
        chk("rst_tick_x", projectileCenterX, 200);
        chk("rst_tick_y", projectileCenterY, 460);
        chk("rst_tick_power", power, 8);
        chk("rst_tick_angle", angleIdx, 3);
        frameTick = 1'b0; q_Animate = 1'b0; Reset = 1'b0; tick();
        chk("post_rst_x", projectileCenterX, 200);
        chk("post_rst_inflight", inFlight, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
